// File: rtl/hand_bbox_extractor.sv
// Per-frame hand pixel count and bounding box over a raster-order binary pixel stream.
// Optional HAND_CENTROID_EN adds row/column index sums for centroid computation.
module hand_bbox_extractor #(
  parameter int unsigned LENGTH = 30,
  parameter int unsigned WIDTH  = 30,
  parameter int unsigned ROW_W  = $clog2(LENGTH),
  parameter int unsigned COL_W  = $clog2(WIDTH),
  parameter int unsigned CNT_W  = $clog2(LENGTH * WIDTH + 1)
) (
  input  logic             slow_clk,
  input  logic             dbnc_rst,
  input  logic             pix_valid,
  input  logic             pix_bit,
  input  logic             pix_sof,
  output logic             pix_ready,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] hand_count,
  output logic             hand_present,
  output logic [ROW_W-1:0] min_row,
  output logic [ROW_W-1:0] max_row,
  output logic [COL_W-1:0] min_col,
  output logic [COL_W-1:0] max_col,
`ifdef HAND_CENTROID_EN
  output logic             frame_restart,
  output logic [ROW_W+CNT_W-1:0] row_sum,
  output logic [COL_W+CNT_W-1:0] col_sum
`else
  output logic             frame_restart
`endif
);

  localparam logic [ROW_W-1:0] RowLast = ROW_W'(LENGTH - 1);
  localparam logic [COL_W-1:0] ColLast = COL_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, amin_row_q, amin_row_d, amax_row_q, amax_row_d;
  logic [COL_W-1:0] col_q, col_d, amin_col_q, amin_col_d, amax_col_q, amax_col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, res_cnt_q, res_cnt_d;
  logic             res_present_q, res_present_d, restart_q, restart_d;
  logic [ROW_W-1:0] res_min_row_q, res_min_row_d, res_max_row_q, res_max_row_d;
  logic [COL_W-1:0] res_min_col_q, res_min_col_d, res_max_col_q, res_max_col_d;
`ifdef HAND_CENTROID_EN
  logic [ROW_W+CNT_W-1:0] rsum_q, rsum_d, res_rsum_q, res_rsum_d;
  logic [COL_W+CNT_W-1:0] csum_q, csum_d, res_csum_q, res_csum_d;
`endif

  logic             accept, restart, last;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;

  assign pix_ready    = (state_q != StDone);
  assign result_valid = (state_q == StDone);
  assign accept       = pix_valid && pix_ready;
  // A mid-frame SOF re-bases the current pixel to (0,0) of a fresh frame.
  assign restart      = accept && pix_sof && (state_q == StAccum) &&
                        ((row_q != '0) || (col_q != '0));
  assign cur_row      = restart ? '0 : row_q;
  assign cur_col      = restart ? '0 : col_q;
  assign last         = (cur_row == RowLast) && (cur_col == ColLast);

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    cnt_d         = cnt_q;
    amin_row_d    = amin_row_q;
    amax_row_d    = amax_row_q;
    amin_col_d    = amin_col_q;
    amax_col_d    = amax_col_q;
    res_cnt_d     = res_cnt_q;
    res_present_d = res_present_q;
    res_min_row_d = res_min_row_q;
    res_max_row_d = res_max_row_q;
    res_min_col_d = res_min_col_q;
    res_max_col_d = res_max_col_q;
    restart_d     = 1'b0;
`ifdef HAND_CENTROID_EN
    rsum_d        = rsum_q;
    csum_d        = csum_q;
    res_rsum_d    = res_rsum_q;
    res_csum_d    = res_csum_q;
`endif
    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          restart_d = restart;
          if (restart) begin
            cnt_d      = '0;
            amin_row_d = RowLast;
            amax_row_d = '0;
            amin_col_d = ColLast;
            amax_col_d = '0;
`ifdef HAND_CENTROID_EN
            rsum_d     = '0;
            csum_d     = '0;
`endif
          end
          if (pix_bit) begin
            cnt_d = cnt_d + CNT_W'(1);
            if (cur_row < amin_row_d) amin_row_d = cur_row;
            if (cur_row > amax_row_d) amax_row_d = cur_row;
            if (cur_col < amin_col_d) amin_col_d = cur_col;
            if (cur_col > amax_col_d) amax_col_d = cur_col;
`ifdef HAND_CENTROID_EN
            rsum_d = rsum_d + {{CNT_W{1'b0}}, cur_row};
            csum_d = csum_d + {{CNT_W{1'b0}}, cur_col};
`endif
          end
          if (last) begin
            state_d       = StDone;
            row_d         = '0;
            col_d         = '0;
            res_cnt_d     = cnt_d;
            res_present_d = (cnt_d != '0);
            // Empty frame reports a zero box rather than the min/max init values.
            res_min_row_d = (cnt_d != '0) ? amin_row_d : '0;
            res_max_row_d = (cnt_d != '0) ? amax_row_d : '0;
            res_min_col_d = (cnt_d != '0) ? amin_col_d : '0;
            res_max_col_d = (cnt_d != '0) ? amax_col_d : '0;
`ifdef HAND_CENTROID_EN
            res_rsum_d    = (cnt_d != '0) ? rsum_d : '0;
            res_csum_d    = (cnt_d != '0) ? csum_d : '0;
`endif
          end else begin
            state_d = StAccum;
            if (cur_col == ColLast) begin
              col_d = '0;
              row_d = cur_row + ROW_W'(1);
            end else begin
              col_d = cur_col + COL_W'(1);
              row_d = cur_row;
            end
          end
        end
      end
      StDone: begin
        if (result_ready) begin
          state_d    = StIdle;
          row_d      = '0;
          col_d      = '0;
          cnt_d      = '0;
          amin_row_d = RowLast;
          amax_row_d = '0;
          amin_col_d = ColLast;
          amax_col_d = '0;
`ifdef HAND_CENTROID_EN
          rsum_d     = '0;
          csum_d     = '0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge slow_clk or posedge dbnc_rst) begin
    if (dbnc_rst) begin
      state_q       <= StIdle;
      row_q         <= '0;
      col_q         <= '0;
      cnt_q         <= '0;
      amin_row_q    <= RowLast;
      amax_row_q    <= '0;
      amin_col_q    <= ColLast;
      amax_col_q    <= '0;
      res_cnt_q     <= '0;
      res_present_q <= 1'b0;
      res_min_row_q <= '0;
      res_max_row_q <= '0;
      res_min_col_q <= '0;
      res_max_col_q <= '0;
      restart_q     <= 1'b0;
`ifdef HAND_CENTROID_EN
      rsum_q        <= '0;
      csum_q        <= '0;
      res_rsum_q    <= '0;
      res_csum_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      cnt_q         <= cnt_d;
      amin_row_q    <= amin_row_d;
      amax_row_q    <= amax_row_d;
      amin_col_q    <= amin_col_d;
      amax_col_q    <= amax_col_d;
      res_cnt_q     <= res_cnt_d;
      res_present_q <= res_present_d;
      res_min_row_q <= res_min_row_d;
      res_max_row_q <= res_max_row_d;
      res_min_col_q <= res_min_col_d;
      res_max_col_q <= res_max_col_d;
      restart_q     <= restart_d;
`ifdef HAND_CENTROID_EN
      rsum_q        <= rsum_d;
      csum_q        <= csum_d;
      res_rsum_q    <= res_rsum_d;
      res_csum_q    <= res_csum_d;
`endif
    end
  end

  assign hand_count    = res_cnt_q;
  assign hand_present  = res_present_q;
  assign min_row       = res_min_row_q;
  assign max_row       = res_max_row_q;
  assign min_col       = res_min_col_q;
  assign max_col       = res_max_col_q;
  assign frame_restart = restart_q;
`ifdef HAND_CENTROID_EN
  assign row_sum       = res_rsum_q;
  assign col_sum       = res_csum_q;
`endif

endmodule

// File: doc/hand_bbox_extractor.md
Name: hand_bbox_extractor

Overview:
Downstream consumer of the thresholded binary hand image. It accepts the filtered hand bits as a raster-order pixel stream with a valid/ready handshake. Over each frame it accumulates the hand-pixel count and the bounding box of set pixels, then presents one result record to the classifier front end under a valid/ready handshake.

Parameters:
- LENGTH, 30: rows per frame.
- WIDTH, 30: columns per frame.
- ROW_W, $clog2(LENGTH): row index width.
- COL_W, $clog2(WIDTH): column index width.
- CNT_W, $clog2(LENGTH*WIDTH+1): pixel count width.

Ports:
- slow_clk  in  1  block clock.
- dbnc_rst  in  1  reset, asynchronous, active-high.
- pix_valid  in  1  pixel present.
- pix_bit  in  1  filtered hand bit; 1 = hand.
- pix_sof  in  1  marks the pixel at (0,0); restarts the frame.
- pix_ready  out  1  block can accept a pixel.
- result_valid  out  1  result record valid.
- result_ready  in  1  consumer takes the record.
- hand_count  out  CNT_W  number of set pixels.
- hand_present  out  1  hand_count != 0.
- min_row, max_row  out  ROW_W  bounding box rows.
- min_col, max_col  out  COL_W  bounding box columns.
- frame_restart  out  1  one-cycle pulse when pix_sof arrives mid-frame.

Behaviour:
- Reset is dbnc_rst, asynchronous, active-high; the block is clocked on slow_clk.
- On reset:
  - State goes to IDLE.
  - Every output is 0 except pix_ready, which is 1.
  - Row and column counters are 0; count is 0.
  - Internal minima load LENGTH-1 / WIDTH-1; internal maxima load 0.
- A pixel is accepted when pix_valid && pix_ready. Gaps in pix_valid are legal; with no accept, nothing changes.
- States:
  - IDLE: pix_ready=1. The first accepted pixel goes to ACCUM, whether or not pix_sof is set.
  - ACCUM: pix_ready=1. Every accept advances the column. At column WIDTH-1 the column returns to 0 and the row increments.
    - Accepting pixel (LENGTH-1, WIDTH-1) moves the state to DONE and latches the result registers.
  - DONE: pix_ready=0 and result_valid=1. Outputs hold stable and pix_valid is ignored.
    - result_ready=1 moves the state to IDLE on the next edge, which also clears counters, count, min and max.
    - result_valid=0 from that next cycle.
- Per accept with pix_bit=1:
  - count increments (saturation is not needed; max is LENGTH*WIDTH).
  - min_row, max_row, min_col and max_col update using the current (row, col). Updates use the pre-increment indices.
- Latency: result_valid rises on the first edge after the edge that accepts the last pixel.
- Empty frame (count=0): hand_present=0, and all bbox outputs are forced to 0, not the internal init values.
- pix_sof=1 on an accepted pixel while in ACCUM with (row,col) != (0,0):
  - The frame restarts. That pixel is treated as (0,0) of a new frame, and count/min/max reinitialise before the pixel is applied.
  - frame_restart pulses high for 1 cycle.
- pix_sof in IDLE, or at (0,0), has no extra effect.
- pix_sof=0 on the first pixel is tolerated: the frame starts at (0,0) regardless.
- result_ready is ignored outside DONE.
- dbnc_rst mid-frame or in DONE: the partial frame is discarded, with the immediate reset values above.
- Result outputs change only on DONE entry and on reset; clearing on DONE exit does not drive the outputs to 0.

Optional Feature:
- HAND_CENTROID_EN: adds outputs row_sum (ROW_W+CNT_W bits) and col_sum (COL_W+CNT_W bits).
  - These are sums of row and column indices over set pixels, accumulated alongside count and latched into DONE under the same rules.
  - Both are forced to 0 for an empty frame.
  - Reset, restart and clear behave like count.
  - The classifier divides by hand_count for the centroid.
- Without the macro, these ports and their accumulators do not exist.

Test Plan:
All tests use LENGTH=4, WIDTH=4 unless noted.
- All-zero frame, 16 back-to-back pixels:
  - result_valid=1 exactly 1 cycle after the 16th accept.
  - hand_count=0, hand_present=0, all bbox outputs=0, pix_ready=0 in DONE.
- Single set pixel at (2,1), with random pix_valid gaps:
  - hand_count=1.
  - min_row=max_row=2, min_col=max_col=1.
- Set pixels at (0,3), (3,0), (1,2):
  - hand_count=3.
  - min_row=0, max_row=3, min_col=0, max_col=3.
  - With HAND_CENTROID_EN: row_sum=4, col_sum=5.
- Backpressure: hold result_ready=0 for 10 cycles while driving pix_valid=1.
  - Outputs stay stable, pix_ready=0, and no pixel is accepted.
  - Pulsing result_ready=1 gives IDLE next cycle.
  - A following frame with one set pixel at (3,3) reports count=1 and bbox 3/3/3/3.
- Restart: 7 pixels including a 1 at (0,2), then pix_sof with a new 16-pixel frame containing a single 1 at (1,1):
  - frame_restart pulses once.
  - Result is count=1 with bbox 1/1/1/1.
- Assert dbnc_rst after 9 accepts:
  - Outputs are 0 and pix_ready=1 immediately.
  - After release, a full all-ones frame reports count=16 with bbox 0/3/0/3.
